// File: rtl/change_dispenser.sv
// Coin-eject sequencer for the vending change path: dispenses the dollar coin first,
// then the quarters, confirming each coin via the drop sensor and latching a jam on timeout.
module change_dispenser #(
  parameter int unsigned PULSE_CYCLES   = 4,
  parameter int unsigned GAP_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [2:0] req_quarters,
  input  logic       req_dollar,
  output logic       req_ready,
  output logic       eject_quarter,
  output logic       eject_dollar,
  input  logic       coin_sensed,
  input  logic       jam_clear,
  output logic       busy,
  output logic       done,
  output logic       jam,
  output logic [2:0] quarters_left,
  output logic       dollar_left
);

  typedef enum logic [2:0] {
    IDLE,
    D_PULSE,
    Q_PULSE,
    WAIT,
    GAP,
    DONE,
    JAM
  } state_t;

  localparam logic [7:0] PULSE_LAST   = 8'(PULSE_CYCLES - 1);
  localparam logic [7:0] GAP_LAST     = 8'(GAP_CYCLES - 1);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     state;
  logic [7:0] timer;
  logic       sense_seen;
  logic [2:0] q_cnt;
  logic       d_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      timer      <= '0;
      sense_seen <= 1'b0;
      q_cnt      <= '0;
      d_cnt      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            q_cnt      <= req_quarters;
            d_cnt      <= req_dollar;
            timer      <= '0;
            sense_seen <= 1'b0;
            if (req_dollar)
              state <= D_PULSE;
            else if (req_quarters != '0)
              state <= Q_PULSE;
            else
              state <= DONE;
          end
        end

        D_PULSE, Q_PULSE: begin
          sense_seen <= sense_seen | coin_sensed;
          if (timer == PULSE_LAST) begin
            timer <= '0;
            state <= WAIT;
          end else begin
            timer <= timer + 8'd1;
          end
        end

        // A sense captured during the pulse, or live this cycle, confirms the coin.
        WAIT: begin
          if (sense_seen || coin_sensed) begin
            timer <= '0;
            if (d_cnt) begin
              d_cnt <= 1'b0;
              state <= (q_cnt == '0) ? DONE : GAP;
            end else begin
              if (q_cnt != '0)
                q_cnt <= q_cnt - 3'd1;
              state <= (q_cnt <= 3'd1) ? DONE : GAP;
            end
          end else if (timer == TIMEOUT_LAST) begin
            timer <= '0;
            state <= JAM;
          end else begin
            timer <= timer + 8'd1;
          end
        end

        GAP: begin
          if (timer == GAP_LAST) begin
            timer      <= '0;
            sense_seen <= 1'b0;
            state      <= d_cnt ? D_PULSE : Q_PULSE;
          end else begin
            timer <= timer + 8'd1;
          end
        end

        DONE: state <= IDLE;

        JAM: begin
          if (jam_clear) begin
            q_cnt <= '0;
            d_cnt <= 1'b0;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready     = (state == IDLE);
  assign eject_dollar  = (state == D_PULSE);
  assign eject_quarter = (state == Q_PULSE);
  assign busy          = (state != IDLE) && (state != JAM);
  assign done          = (state == DONE);
  assign jam           = (state == JAM);
  assign quarters_left = q_cnt;
  assign dollar_left   = d_cnt;

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized bench for change_dispenser: builds each request's expected per-cycle
// output timeline from the coin-order and timing rules, then replays it against the DUT.
module tb_change_dispenser;

  localparam int unsigned PULSE = 4;
  localparam int unsigned GAPC  = 4;
  localparam int unsigned TMO   = 16;

  localparam logic [2:0] PH_PULSE = 3'd0;
  localparam logic [2:0] PH_WAIT  = 3'd1;
  localparam logic [2:0] PH_GAP   = 3'd2;
  localparam logic [2:0] PH_DONE  = 3'd3;
  localparam logic [2:0] PH_JAM   = 3'd4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic [2:0] req_quarters = '0;
  logic       req_dollar = 1'b0;
  logic       coin_sensed = 1'b0;
  logic       jam_clear = 1'b0;
  logic       req_ready, eject_quarter, eject_dollar, busy, done, jam, dollar_left;
  logic [2:0] quarters_left;
  logic [9:0] obs;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  typedef struct {
    logic       sense;
    logic       jclr;
    logic       rst;
    logic [2:0] ph;
    logic [9:0] exp;
  } step_t;

  step_t sched[$];

  always #5 clk = ~clk;

  change_dispenser #(
    .PULSE_CYCLES  (PULSE),
    .GAP_CYCLES    (GAPC),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_quarters (req_quarters),
    .req_dollar   (req_dollar),
    .req_ready    (req_ready),
    .eject_quarter(eject_quarter),
    .eject_dollar (eject_dollar),
    .coin_sensed  (coin_sensed),
    .jam_clear    (jam_clear),
    .busy         (busy),
    .done         (done),
    .jam          (jam),
    .quarters_left(quarters_left),
    .dollar_left  (dollar_left)
  );

  assign obs = {req_ready, eject_quarter, eject_dollar, busy, done, jam, quarters_left, dollar_left};

  // Vector layout: ready, ejq, ejd, busy, done, jam, quarters[2:0], dollar
  task automatic check(input string tag, input logic [9:0] observed, input logic [9:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s @%0t: got %b expected %b", tag, $time, observed, expected);
    end
  endtask

  function automatic logic [9:0] ev(input logic rr, input logic eq, input logic ed, input logic b,
                                     input logic dn, input logic jm, input int ql, input int dl);
    return {rr, eq, ed, b, dn, jm, 3'(ql), 1'(dl)};
  endfunction

  function automatic string ph_name(input logic [2:0] ph);
    case (ph)
      PH_PULSE: return "pulse";
      PH_WAIT:  return "wait";
      PH_GAP:   return "gap";
      PH_DONE:  return "done";
      default:  return "jam";
    endcase
  endfunction

  function automatic logic rbit(input int unsigned one_in);
    return 1'($urandom_range(0, one_in - 1) == 0);
  endfunction

  task automatic push(input logic s, input logic jc, input logic r, input logic [2:0] ph,
                      input logic [9:0] e);
    step_t st;
    st.sense = s; st.jclr = jc; st.rst = r; st.ph = ph; st.exp = e;
    sched.push_back(st);
  endtask

  // fmode: -1 random per coin, 0 sense in first WAIT cycle, 1 sense in 2nd pulse cycle,
  // 2 never sense (jam on first coin). abort_coin: coin index whose 2nd pulse cycle gets reset.
  task automatic build(input int q, input int d, input int fmode, input int abort_coin);
    int ql = q;
    int dl = d;
    int n  = q + d;
    sched.delete();
    if (n == 0) begin
      push(rbit(2), rbit(4), 1'b0, PH_DONE, ev(0, 0, 0, 1, 1, 0, 0, 0));
      return;
    end
    for (int c = 0; c < n; c++) begin
      logic is_d = (dl != 0);
      int   mode, p, k, r;
      if (fmode >= 0) begin
        mode = fmode; p = 1; k = 0;
      end else begin
        r    = int'($urandom_range(0, 15));
        mode = (r == 0) ? 2 : (r < 6) ? 1 : 0;
        p    = int'($urandom_range(0, PULSE - 1));
        k    = int'($urandom_range(0, TMO - 1));
      end
      for (int i = 0; i < int'(PULSE); i++) begin
        if (c == abort_coin && i == 1) begin
          push(1'b0, 1'b0, 1'b1, PH_PULSE, ev(0, !is_d, is_d, 1, 0, 0, ql, dl));
          return;
        end
        push(1'(mode == 1 && i == p), rbit(4), 1'b0, PH_PULSE, ev(0, !is_d, is_d, 1, 0, 0, ql, dl));
      end
      if (mode == 2) begin
        int nj = int'($urandom_range(1, 4));
        for (int i = 0; i < int'(TMO); i++)
          push(1'b0, rbit(4), 1'b0, PH_WAIT, ev(0, 0, 0, 1, 0, 0, ql, dl));
        for (int j = 0; j < nj; j++)
          push(rbit(2), 1'(j == nj - 1), 1'b0, PH_JAM, ev(0, 0, 0, 0, 0, 1, ql, dl));
        return;
      end
      if (mode == 1) begin
        push(1'b0, rbit(4), 1'b0, PH_WAIT, ev(0, 0, 0, 1, 0, 0, ql, dl));
      end else begin
        for (int i = 0; i < k; i++)
          push(1'b0, rbit(4), 1'b0, PH_WAIT, ev(0, 0, 0, 1, 0, 0, ql, dl));
        push(1'b1, rbit(4), 1'b0, PH_WAIT, ev(0, 0, 0, 1, 0, 0, ql, dl));
      end
      if (is_d) dl = 0;
      else      ql = ql - 1;
      if (ql == 0 && dl == 0) begin
        push(rbit(2), rbit(4), 1'b0, PH_DONE, ev(0, 0, 0, 1, 1, 0, 0, 0));
      end else begin
        for (int i = 0; i < int'(GAPC); i++)
          push(rbit(2), rbit(4), 1'b0, PH_GAP, ev(0, 0, 0, 1, 0, 0, ql, dl));
      end
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    reset = 1'b0; req_valid = 1'b0; jam_clear = rbit(2); coin_sensed = rbit(2);
    check("idle", obs, ev(1, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic run_txn(input int q, input int d, input int fmode, input int abort_coin);
    @(negedge clk);
    reset = 1'b0; jam_clear = rbit(2); coin_sensed = rbit(2);
    check("accept", obs, ev(1, 0, 0, 0, 0, 0, 0, 0));
    req_valid = 1'b1; req_quarters = 3'(q); req_dollar = 1'(d);
    build(q, d, fmode, abort_coin);
    foreach (sched[i]) begin
      @(negedge clk);
      req_valid    = rbit(2);
      req_quarters = 3'($urandom_range(0, 7));
      req_dollar   = rbit(2);
      coin_sensed  = sched[i].sense;
      jam_clear    = sched[i].jclr;
      reset        = sched[i].rst;
      check(ph_name(sched[i].ph), obs, sched[i].exp);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b1; req_quarters = 3'd5; req_dollar = 1'b1;
    repeat (2) @(negedge clk);
    check("reset", obs, ev(1, 0, 0, 0, 0, 0, 0, 0));
    coin_sensed = 1'b1; jam_clear = 1'b1;
    @(negedge clk);
    check("reset_hold", obs, ev(1, 0, 0, 0, 0, 0, 0, 0));

    run_txn(0, 0, 0, -1);   // empty request
    run_txn(1, 0, 0, -1);   // single quarter
    run_txn(3, 1, 0, -1);   // dollar then three quarters
    run_txn(2, 0, 2, -1);   // jam on first quarter, then clear
    run_txn(2, 1, 1, -1);   // sense during pulse
    run_txn(3, 0, 0, 1);    // reset during 2nd quarter pulse
    idle_cycle();

    for (int t = 0; t < 120; t++) begin
      int ab;
      ab = (rbit(10) != 0) ? int'($urandom_range(0, 7)) : -1;
      run_txn(int'($urandom_range(0, 7)), int'($urandom_range(0, 1)), -1, ab);
      if (rbit(3) != 0) idle_cycle();
    end
    idle_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
